// File: rtl/carbon_arch_pkg.sv
// rtl/carbon_arch_pkg.sv - shared fabric widths, opcodes and response codes
// Purpose: common constants for fabric masters and slaves.
// Ports: none (package).
package carbon_arch_pkg;

  localparam int CARBON_FABRIC_ATTR_WIDTH_BITS = 4;

  localparam logic [7:0] CARBON_FABRIC_XACT_READ       = 8'h01;
  localparam logic [7:0] CARBON_FABRIC_XACT_WRITE      = 8'h02;

  localparam logic [7:0] CARBON_FABRIC_RESP_OK         = 8'h00;
  localparam logic [7:0] CARBON_FABRIC_RESP_DECODE_ERR = 8'h02;

endpackage

// File: rtl/fabric_memtest_master_if.sv
// rtl/fabric_memtest_master_if.sv - fabric_if request/response bus
// Purpose: one request channel (valid/ready) and one response channel (valid/ready)
// Ports (modport master drives req_* fields and rsp_ready; slave drives req_ready and rsp_*):
//   req_valid/req_ready, req_addr, req_op, req_size, req_attr, req_wdata, req_wstrb, req_id
//   rsp_valid/rsp_ready, rsp_rdata, rsp_code, rsp_id
interface fabric_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int OP_W   = 8,
  parameter int SIZE_W = 3,
  parameter int ATTR_W = carbon_arch_pkg::CARBON_FABRIC_ATTR_WIDTH_BITS,
  parameter int CODE_W = 8
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic [OP_W-1:0]       req_op;
  logic [SIZE_W-1:0]     req_size;
  logic [ATTR_W-1:0]     req_attr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic [ID_W-1:0]       req_id;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic [CODE_W-1:0]     rsp_code;
  logic [ID_W-1:0]       rsp_id;

  modport master (
    output req_valid, req_addr, req_op, req_size, req_attr, req_wdata, req_wstrb, req_id,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_code, rsp_id
  );

  modport slave (
    input  req_valid, req_addr, req_op, req_size, req_attr, req_wdata, req_wstrb, req_id,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_code, rsp_id
  );

endinterface

// File: rtl/fabric_memtest_master.sv
// rtl/fabric_memtest_master.sv - write-then-readback memory test master for fabric_if slaves
// Purpose: writes NUM_WORDS LFSR words from BASE_ADDR, reads them back, checks code/id/data.
// Ports:
//   clk, rst_n (async active-low), start (pulse)
//   busy, done, pass, timeout, err_count[15:0], first_err_addr[ADDR_W-1:0]
//   bus : fabric_if.master, one outstanding transaction
module fabric_memtest_master
  import carbon_arch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                ID_W      = 4,
  parameter int                OP_W      = 8,
  parameter int                SIZE_W    = 3,
  parameter int                ATTR_W    = CARBON_FABRIC_ATTR_WIDTH_BITS,
  parameter int                CODE_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                NUM_WORDS = 16,
  parameter logic [31:0]       SEED      = 32'hACE1,
  parameter int                MAX_WAIT  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  fabric_if.master          bus
);

  localparam int          BPW      = DATA_W / 8;
  localparam int          IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int          WAIT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RSP,
    S_RD_REQ,
    S_RD_RSP,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [15:0]         err_count_q, err_count_d;
  logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;
  logic                timeout_q, timeout_d;

  logic [DATA_W-1:0]   pattern;
  logic [ADDR_W-1:0]   req_addr;
  logic [ID_W-1:0]     req_id;
  logic                in_req, in_rsp, is_read;
  logic                req_fire, rsp_fire, rsp_err, wait_expired;

  // Fibonacci shift-left step for x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  // The 32-bit LFSR is tiled across the data word (truncated for narrow buses).
  for (genvar g = 0; g < DATA_W; g++) begin : g_pattern
    assign pattern[g] = lfsr_q[g % 32];
  end

  assign in_req   = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
  assign in_rsp   = (state_q == S_WR_RSP) || (state_q == S_RD_RSP);
  assign is_read  = (state_q == S_RD_REQ) || (state_q == S_RD_RSP);
  assign req_addr = BASE_ADDR + ADDR_W'(idx_q) * ADDR_W'(BPW);
  assign req_id   = ID_W'(idx_q);

  // Request fields depend only on flops that hold still until the
  // request fires, so they are stable across ready stalls by construction.
  assign bus.req_valid = in_req;
  assign bus.req_addr  = req_addr;
  assign bus.req_op    = is_read ? OP_W'(CARBON_FABRIC_XACT_READ) : OP_W'(CARBON_FABRIC_XACT_WRITE);
  assign bus.req_size  = SIZE_W'($clog2(BPW));
  assign bus.req_attr  = ATTR_W'(0);
  assign bus.req_wdata = pattern;
  assign bus.req_wstrb = '1;
  assign bus.req_id    = req_id;
  assign bus.rsp_ready = in_rsp;

  assign req_fire     = bus.req_valid && bus.req_ready;
  assign rsp_fire     = bus.rsp_valid && bus.rsp_ready;
  assign wait_expired = (wait_cnt_q == WAIT_LIM);
  assign rsp_err      = (bus.rsp_code != CODE_W'(CARBON_FABRIC_RESP_OK)) ||
                        (bus.rsp_id != req_id) ||
                        (is_read && (bus.rsp_rdata != pattern));

  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = (state_q == S_DONE);
  assign pass           = done && (err_count_q == 16'd0) && !timeout_q;
  assign timeout        = timeout_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    lfsr_d           = lfsr_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    timeout_d        = timeout_q;
    wait_cnt_d       = wait_cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d          = S_WR_REQ;
          idx_d            = '0;
          lfsr_d           = SEED_EFF;
          err_count_d      = '0;
          first_err_addr_d = '0;
          timeout_d        = 1'b0;
        end
      end
      S_WR_REQ, S_RD_REQ: begin
        if (req_fire) begin
          state_d = (state_q == S_WR_REQ) ? S_WR_RSP : S_RD_RSP;
        end else if (wait_expired) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_WR_RSP, S_RD_RSP: begin
        if (rsp_fire) begin
          lfsr_d = lfsr_step(lfsr_q);
          if (rsp_err) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (err_count_q == 16'd0)    first_err_addr_d = req_addr;
          end
          if (idx_q == LAST_IDX) begin
            if (state_q == S_WR_RSP) begin
              // Restart the sequence so the read pass expects what was written.
              state_d = S_RD_REQ;
              idx_d   = '0;
              lfsr_d  = SEED_EFF;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = (state_q == S_WR_RSP) ? S_WR_REQ : S_RD_REQ;
          end
        end else if (wait_expired) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)   wait_cnt_d = '0;
    else if (in_req || in_rsp) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      lfsr_q           <= SEED_EFF;
      wait_cnt_q       <= '0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      timeout_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      lfsr_q           <= lfsr_d;
      wait_cnt_q       <= wait_cnt_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      timeout_q        <= timeout_d;
    end
  end

endmodule

// File: tb/tb_fabric_memtest_master.sv
// tb/tb_fabric_memtest_master.sv - scoreboard bench for fabric_memtest_master
module tb_fabric_memtest_master;
  import carbon_arch_pkg::*;

  localparam int N        = 16;
  localparam int MAX_WAIT = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;

  fabric_if bus_if ();

  fabric_memtest_master #(
    .NUM_WORDS (N),
    .SEED      (32'hACE1),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .bus            (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  op;
    logic [31:0] data;
    logic [3:0]  id;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          fires  = 0;
  int          mode   = 0;  // 0 plain, 1 latency+stalls, 2 corrupt 0x18, 3 decode>=0x20, 4 mute
  logic [31:0] mem [0:63];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Polynomial x^32+x^22+x^2+x+1: feedback is the parity of the tapped bits.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {v[30:0], ^(v & 32'h8020_0003)};
  endfunction

  task automatic push_expected();
    exp_t        e;
    logic [31:0] l;
    exp_q.delete();
    for (int p = 0; p < 2; p++) begin
      l = 32'hACE1;
      for (int i = 0; i < N; i++) begin
        e.addr = 32'(i * 4);
        e.op   = (p == 0) ? CARBON_FABRIC_XACT_WRITE : CARBON_FABRIC_XACT_READ;
        e.data = l;
        e.id   = 4'(i);
        exp_q.push_back(e);
        l = lfsr_next(l);
      end
    end
  endtask

  // Slave model: memory array, optional latency, ready stalls and fault injection.
  initial begin : slave_proc
    logic        req_fire_p, rsp_fire_p, have_rsp;
    int          cnt, stall;
    logic [31:0] cap_addr, cap_data, r_data;
    logic [7:0]  cap_op, r_code;
    logic [3:0]  cap_id, r_id;
    req_fire_p = 0; rsp_fire_p = 0; have_rsp = 0; cnt = 0; stall = 0;
    cap_addr = 0; cap_data = 0; cap_op = 0; cap_id = 0;
    r_data = 0; r_code = 0; r_id = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    bus_if.req_ready = 1'b0;
    bus_if.rsp_valid = 1'b0;
    bus_if.rsp_rdata = '0;
    bus_if.rsp_code  = '0;
    bus_if.rsp_id    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus_if.rsp_valid = 1'b0;
        bus_if.req_ready = 1'b0;
        req_fire_p = 0; rsp_fire_p = 0; have_rsp = 0;
      end else begin
        if (rsp_fire_p) bus_if.rsp_valid = 1'b0;
        if (req_fire_p) begin
          r_id   = cap_id;
          r_code = CARBON_FABRIC_RESP_OK;
          r_data = 32'h0;
          if (mode == 3 && cap_addr >= 32'h20) begin
            r_code = CARBON_FABRIC_RESP_DECODE_ERR;
          end else if (cap_op == CARBON_FABRIC_XACT_WRITE) begin
            mem[cap_addr[7:2]] = cap_data;
          end else begin
            r_data = mem[cap_addr[7:2]];
            if (mode == 2 && cap_addr == 32'h18) r_data[0] = ~r_data[0];
          end
          have_rsp = (mode != 4);
          cnt      = (mode == 1) ? 3 : 0;
        end
        if (have_rsp && !bus_if.rsp_valid) begin
          if (cnt == 0) begin
            bus_if.rsp_valid = 1'b1;
            bus_if.rsp_rdata = r_data;
            bus_if.rsp_code  = r_code;
            bus_if.rsp_id    = r_id;
            have_rsp = 0;
          end else begin
            cnt--;
          end
        end
        if (mode == 1) begin
          if (stall >= 3 || $urandom_range(0, 1) == 1) begin
            bus_if.req_ready = 1'b1; stall = 0;
          end else begin
            bus_if.req_ready = 1'b0; stall++;
          end
        end else begin
          bus_if.req_ready = 1'b1;
        end
        req_fire_p = bus_if.req_valid && bus_if.req_ready;
        rsp_fire_p = bus_if.rsp_valid && bus_if.rsp_ready;
        if (req_fire_p) begin
          cap_addr = bus_if.req_addr;
          cap_data = bus_if.req_wdata;
          cap_op   = bus_if.req_op;
          cap_id   = bus_if.req_id;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every request fire and checks stall stability.
  initial begin : monitor_proc
    logic        prev_stall;
    logic [31:0] s_addr, s_data;
    logic [7:0]  s_op;
    logic [3:0]  s_id;
    exp_t        e;
    prev_stall = 0; s_addr = 0; s_data = 0; s_op = 0; s_id = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall && bus_if.req_valid)
          check("stall_stable", {bus_if.req_addr, bus_if.req_wdata ^ {bus_if.req_op, 20'h0, bus_if.req_id}},
                {s_addr, s_data ^ {s_op, 20'h0, s_id}});
        if (bus_if.req_valid && bus_if.req_ready) begin
          fires++;
          if (exp_q.size() == 0) begin
            check("unexpected_req", 64'(bus_if.req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("req_addr", 64'(bus_if.req_addr), 64'(e.addr));
            check("req_op",   64'(bus_if.req_op),   64'(e.op));
            check("req_id",   64'(bus_if.req_id),   64'(e.id));
            check("req_misc", {56'h0, bus_if.req_wstrb, bus_if.req_size, bus_if.req_attr[0]},
                              {56'h0, 4'hF, 3'd2, 1'b0});
            if (e.op == CARBON_FABRIC_XACT_WRITE)
              check("req_wdata", 64'(bus_if.req_wdata), 64'(e.data));
          end
        end
        prev_stall = bus_if.req_valid && !bus_if.req_ready;
        s_addr = bus_if.req_addr; s_data = bus_if.req_wdata;
        s_op   = bus_if.req_op;   s_id   = bus_if.req_id;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    push_expected();
    fires = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input int budget, output int rsp_cycles);
    int n;
    n = 0;
    rsp_cycles = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      #1;
      if (bus_if.rsp_ready) rsp_cycles++;
      n++;
    end
    check("done_within_budget", 64'(done), 64'd1);
  endtask

  task automatic run(input int m, input logic [15:0] e_err, input logic [31:0] e_fea, input logic e_pass);
    int rc;
    mode = m;
    pulse_start();
    wait_done(3000, rc);
    check("done",           64'(done),           64'd1);
    check("busy_done",      64'(busy),           64'd0);
    check("pass",           64'(pass),           64'(e_pass));
    check("timeout",        64'(timeout),        64'd0);
    check("err_count",      64'(err_count),      64'(e_err));
    check("first_err_addr", 64'(first_err_addr), 64'(e_fea));
    check("xact_count",     64'(fires),          64'd32);
    check("queue_drained",  64'(exp_q.size()),   64'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main_proc
    int rc;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy",      64'(busy),             64'd0);
    check("rst_done",      64'(done),             64'd0);
    check("rst_pass",      64'(pass),             64'd0);
    check("rst_timeout",   64'(timeout),          64'd0);
    check("rst_err_count", 64'(err_count),        64'd0);
    check("rst_first_err", 64'(first_err_addr),   64'd0);
    check("rst_req_valid", 64'(bus_if.req_valid), 64'd0);
    check("rst_rsp_ready", 64'(bus_if.rsp_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 16'd0, 32'h0, 1'b1);
    run(1, 16'd0, 32'h0, 1'b1);
    run(2, 16'd1, 32'h18, 1'b0);
    run(3, 16'd16, 32'h20, 1'b0);

    // Mute slave: one write request, then 1+MAX_WAIT cycles in WR_RSP.
    mode = 4;
    pulse_start();
    wait_done(200, rc);
    check("to_rsp_cycles", 64'(rc),        64'(1 + MAX_WAIT));
    check("to_timeout",    64'(timeout),   64'd1);
    check("to_done",       64'(done),      64'd1);
    check("to_pass",       64'(pass),      64'd0);
    check("to_err_count",  64'(err_count), 64'd0);
    check("to_xact_count", 64'(fires),     64'd1);

    // Reset in the middle of the read pass, then a clean rerun from IDLE.
    mode = 0;
    pulse_start();
    rc = 0;
    while (fires < 20 && rc < 500) begin
      @(negedge clk);
      rc++;
    end
    check("reached_read_pass", 64'(fires >= 20), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", 64'(bus_if.req_valid), 64'd0);
    check("midrst_busy",      64'(busy),             64'd0);
    check("midrst_done",      64'(done),             64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(0, 16'd0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
